// File: rtl/load_store_unit_pkg.sv
// Shared constants for the data-side load/store unit: funct3 codes, address regions, FSM encoding.
// Region codes double as the registered access target inside the unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] REGION_ROM  = 2'b00;
  localparam logic [1:0] REGION_RAM  = 2'b01;
  localparam logic [1:0] REGION_GPIO = 2'b10;
  localparam logic [1:0] REGION_NONE = 2'b11;

  localparam logic [31:0] GPIO_ADDR = 32'h0000_2000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACCESS = 3'b010,
    S_RESP   = 3'b100
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_data_ram.sv
// Data RAM: RAM_WORDS x 32, one registered read port, one byte-enabled write port, no reset.
// Read data appears the cycle after re_i; contents are undefined until written.
module data_ram #(
  parameter int RAM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: ROM/RAM/GPIO decode, fixed 3-cycle accept-to-ready, response in cycle N+2.
// Ready only in IDLE; define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic [9:0]  rom_addr_o,
  input  logic [31:0] rom_rdata_i,
  output logic [7:0]  gpio_o
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  lsu_state_e  state_q, state_d;
  logic [11:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [1:0]  region_q;
  logic [7:0]  gpio_q;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q;

  logic        accept;
  logic [1:0]  low_mask;
  logic [31:0] acc_addr;
  logic        align_fault;
  logic [1:0]  region_d;
  logic        fault_d;

  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    low_mask = 2'b00;
    case (req_funct3_i[1:0])
      2'b01:   low_mask = 2'b01;
      2'b10:   low_mask = 2'b11;
      default: low_mask = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_addr    = req_addr_i;
  assign align_fault = |(req_addr_i[1:0] & low_mask);
`else
  // Truncate to the natural boundary of the access size.
  assign acc_addr    = {req_addr_i[31:2], req_addr_i[1:0] & ~low_mask};
  assign align_fault = 1'b0;
`endif

  always_comb begin
    region_d = REGION_NONE;
    if (acc_addr[31:14] == '0) begin
      case (acc_addr[13:12])
        2'b00: region_d = REGION_ROM;
        2'b01: region_d = (32'(acc_addr[11:2]) >= 32'(RAM_WORDS)) ? REGION_NONE : REGION_RAM;
        2'b10: region_d = (acc_addr[31:2] == GPIO_ADDR[31:2]) ? REGION_GPIO : REGION_NONE;
        default: region_d = REGION_NONE;
      endcase
    end
  end

  assign fault_d = (region_d == REGION_NONE)
                || (req_we_i && (region_d == REGION_ROM))
                || !f3_legal(req_we_i, req_funct3_i)
                || align_fault;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid_i) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    rom_addr_o   = '0;
    case (state_q)
      S_IDLE:   req_ready_o  = 1'b1;
      S_ACCESS: rom_addr_o   = addr_q[11:2];
      S_RESP:   resp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      region_q <= REGION_NONE;
    end else if (accept) begin
      addr_q   <= acc_addr[11:0];
      we_q     <= req_we_i;
      f3_q     <= req_funct3_i;
      wdata_q  <= req_wdata_i;
      fault_q  <= fault_d;
      region_q <= region_d;
    end
  end

  logic        commit;
  logic        ram_we;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] ram_rdata;

  assign commit = (state_q == S_ACCESS) && we_q && !fault_q;
  assign ram_we = commit && (region_q == REGION_RAM);

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << {addr_q[1], 1'b0};
        wr_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  data_ram #(
    .RAM_WORDS(RAM_WORDS),
    .AW       (AW)
  ) u_data_ram (
    .clk_i  (clk_i),
    .re_i   (accept && (region_d == REGION_RAM)),
    .raddr_i(acc_addr[AW+1:2]),
    .rdata_o(ram_rdata),
    .we_i   (ram_we),
    .be_i   (wr_be),
    .waddr_i(addr_q[AW+1:2]),
    .wdata_i(wr_data)
  );

  logic [31:0] raw_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    raw_word = '0;
    case (region_q)
      REGION_ROM:  raw_word = rom_rdata_i;
      REGION_RAM:  raw_word = ram_rdata;
      REGION_GPIO: raw_word = {24'b0, gpio_q};
      default:     raw_word = '0;
    endcase
    case (addr_q[1:0])
      2'b00:   lane_byte = raw_word[7:0];
      2'b01:   lane_byte = raw_word[15:8];
      2'b10:   lane_byte = raw_word[23:16];
      default: lane_byte = raw_word[31:24];
    endcase
    lane_half = addr_q[1] ? raw_word[31:16] : raw_word[15:0];
    resp_rdata_d = '0;
    if (!we_q && !fault_q) begin
      case (f3_q)
        F3_B:    resp_rdata_d = {{24{lane_byte[7]}}, lane_byte};
        F3_BU:   resp_rdata_d = {24'b0, lane_byte};
        F3_H:    resp_rdata_d = {{16{lane_half[15]}}, lane_half};
        F3_HU:   resp_rdata_d = {16'b0, lane_half};
        F3_W:    resp_rdata_d = raw_word;
        default: resp_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_q       <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      if (commit && (region_q == REGION_GPIO)) gpio_q <= wdata_q[7:0];
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= fault_q;
    end
  end

  assign resp_rdata_o = resp_rdata_q;
  assign resp_fault_o = resp_fault_q;
  assign gpio_o       = gpio_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps then randomized accesses against a byte-level memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int RAM_WORDS = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_fault_o;
  logic [9:0]  rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic [7:0]  gpio_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_b [4*RAM_WORDS];
  logic [7:0] m_gpio = 8'h00;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_fault_o(resp_fault_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i),
    .gpio_o      (gpio_o)
  );

  function automatic logic [31:0] rom_word(input logic [9:0] i);
    return ({22'b0, i} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign rom_rdata_i = rom_word(rom_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, region from address ranges.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                                input logic [31:0] wd, output logic f, output logic [31:0] rd);
    int unsigned size;
    int          region;
    logic [31:0] a, word, sh, base;
    bit          legal;
    a  = a_in;
    f  = 1'b0;
    rd = '0;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((a % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      f = 1'b1;
`else
      a = a - (a % size);
`endif
    end
    if (a >= 32'h4000)      region = 3;
    else if (a < 32'h1000)  region = 0;
    else if (a < 32'h2000)  region = (((a - 32'h1000) >> 2) < RAM_WORDS) ? 1 : 3;
    else if (a < 32'h2004)  region = 2;
    else                    region = 3;
    if (region == 3 || !legal || (we && region == 0)) f = 1'b1;
    if (f) return;
    if (we) begin
      if (region == 1) begin
        for (int k = 0; k < int'(size); k++) ram_b[a - 32'h1000 + k] = wd[8*k +: 8];
      end else begin
        m_gpio = wd[7:0];
      end
    end else begin
      case (region)
        0: word = rom_word(a[11:2]);
        1: begin
          base = {a[31:2], 2'b00} - 32'h1000;
          word = {ram_b[base+3], ram_b[base+2], ram_b[base+1], ram_b[base]};
        end
        default: word = {24'b0, m_gpio};
      endcase
      sh = word >> (8 * a[1:0]);
      case (size)
        1:       rd = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        2:       rd = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        default: rd = sh;
      endcase
    end
  endfunction

  // Junk on the request bus while busy: a wrongly accepted store would corrupt checked RAM.
  task automatic scramble();
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = F3_W;
    req_addr_i   = 32'h1000 + ($urandom_range(0, 63) * 4);
    req_wdata_i  = $urandom;
  endtask

  // Called at a falling edge with the unit idle; returns at the falling edge where it is idle again.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] got_rd, output logic got_f);
    logic        ef;
    logic [31:0] er;
    model(we, f3, a, wd, ef, er);
    check({tag, " ready_before"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    @(posedge clk_i);
    #1;
    scramble();
    @(negedge clk_i);
    check({tag, " valid_n1"}, {31'b0, resp_valid_o}, 32'd0);
    check({tag, " ready_n1"}, {31'b0, req_ready_o}, 32'd0);
    scramble();
    @(negedge clk_i);
    got_rd = resp_rdata_o;
    got_f  = resp_fault_o;
    check({tag, " valid_n2"}, {31'b0, resp_valid_o}, 32'd1);
    check({tag, " ready_n2"}, {31'b0, req_ready_o}, 32'd0);
    check({tag, " rdata"}, resp_rdata_o, er);
    check({tag, " fault"}, {31'b0, resp_fault_o}, {31'b0, ef});
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check({tag, " valid_n3"}, {31'b0, resp_valid_o}, 32'd0);
    check({tag, " ready_n3"}, {31'b0, req_ready_o}, 32'd1);
    check({tag, " gpio"}, {24'b0, gpio_o}, {24'b0, m_gpio});
  endtask

  initial begin
    logic [31:0] rd;
    logic        fl;
    logic [31:0] a;
    logic        we;
    logic [2:0]  f3;

    repeat (3) @(negedge clk_i);
    check("rst ready", {31'b0, req_ready_o}, 32'd1);
    check("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst resp_rdata", resp_rdata_o, 32'd0);
    check("rst resp_fault", {31'b0, resp_fault_o}, 32'd0);
    check("rst gpio", {24'b0, gpio_o}, 32'd0);
    check("rst rom_addr", {22'b0, rom_addr_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 64; i++) do_req(1'b1, F3_W, 32'h1000 + i * 4, $urandom, "init", rd, fl);

    do_req(1'b1, F3_W, 32'h1000, 32'h0001_F000, "sw1000", rd, fl);
    do_req(1'b0, F3_W, 32'h1000, 32'h0, "lw1000", rd, fl);
    check("lw1000 value", rd, 32'h0001_F000);

    do_req(1'b1, F3_W, 32'h1004, 32'h80FF_7F01, "sw1004", rd, fl);
    do_req(1'b0, F3_B, 32'h1006, 32'h0, "lb1006", rd, fl);
    check("lb1006 value", rd, 32'hFFFF_FFFF);
    do_req(1'b0, F3_BU, 32'h1007, 32'h0, "lbu1007", rd, fl);
    check("lbu1007 value", rd, 32'h0000_0080);
    do_req(1'b0, F3_H, 32'h1006, 32'h0, "lh1006", rd, fl);
    check("lh1006 value", rd, 32'hFFFF_80FF);
    do_req(1'b0, F3_HU, 32'h1004, 32'h0, "lhu1004", rd, fl);
    check("lhu1004 value", rd, 32'h0000_7F01);

    do_req(1'b1, F3_B, 32'h1005, 32'h0000_00AA, "sb1005", rd, fl);
    do_req(1'b0, F3_W, 32'h1004, 32'h0, "lw1004", rd, fl);
    check("lw1004 value", rd, 32'h80FF_AA01);

    do_req(1'b1, F3_B, 32'h2000, 32'h1234_56C3, "sb_gpio", rd, fl);
    check("gpio value", {24'b0, gpio_o}, 32'h0000_00C3);
    do_req(1'b0, F3_W, 32'h2000, 32'h0, "lw_gpio", rd, fl);
    check("lw_gpio value", rd, 32'h0000_00C3);

    // Reset in the middle of ACCESS of a store: no response, store discarded.
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = F3_W;
    req_addr_i   = 32'h1000;
    req_wdata_i  = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("midrst resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("midrst ready", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_gpio = 8'h00;
    check("midrst gpio", {24'b0, gpio_o}, 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      check("postrst resp_valid", {31'b0, resp_valid_o}, 32'd0);
    end
    do_req(1'b0, F3_W, 32'h1000, 32'h0, "lw_after_rst", rd, fl);
    check("lw_after_rst value", rd, 32'h0001_F000);

    do_req(1'b1, F3_W, 32'h0000, 32'h5555_AAAA, "sw_rom", rd, fl);
    check("sw_rom fault", {31'b0, fl}, 32'd1);
    do_req(1'b0, F3_W, 32'h1000, 32'h0, "lw_after_rom", rd, fl);
    check("lw_after_rom value", rd, 32'h0001_F000);
    do_req(1'b0, F3_W, 32'h3000, 32'h0, "lw3000", rd, fl);
    check("lw3000 fault", {31'b0, fl}, 32'd1);
    check("lw3000 rdata", rd, 32'd0);

    do_req(1'b0, F3_W, 32'h1002, 32'h0, "lw1002", rd, fl);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw1002 fault", {31'b0, fl}, 32'd1);
`else
    check("lw1002 fault", {31'b0, fl}, 32'd0);
    check("lw1002 value", rd, 32'h0001_F000);
`endif

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (we ? 3'($urandom_range(0, 2))
                                                                         : 3'($urandom_range(0, 5)));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'h1000 + $urandom_range(0, 255);
        4, 5:       a = $urandom_range(0, 32'hFFF);
        6, 7:       a = 32'h2000 + $urandom_range(0, 3);
        8:          a = 32'h2004 + $urandom_range(0, 32'h1FFB);
        default:    a = {18'($urandom_range(1, 262143)), 14'($urandom)};
      endcase
      do_req(we, f3, a, $urandom, "rand", rd, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side memory stage of the `riscv` core: accepts one load/store request per handshake from the execute stage, decodes the address into ROM, RAM or GPIO, performs byte/half/word access with RV32I alignment and sign-extension rules, and returns a single-cycle response. Loads and stores to address 0x1000 and above reach a real RAM instead of the instruction ROM. The unit owns the data RAM and the `gpio` output register.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; must be ≤1024 so it fits the 4 KB window.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the LOAD/STORE instruction.
- `req_addr`  in  32  byte address (rs1 + imm).
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  formatted load data; 0 for stores and faults.
- `resp_fault`  out  1  access faulted; no side effects occurred.
- `rom_addr`  out  10  ROM word address; ROM read is combinational.
- `rom_rdata`  in  32  ROM data.
- `gpio`  out  8  GPIO output register.

## Operation
- Address map: `req_addr[31:14]` ≠ 0 → unmapped.
- `[13:12]`=00 → ROM, read-only. 01 → RAM; word index ≥ `RAM_WORDS` → unmapped. 10 with `[11:2]`=0 → GPIO register. Anything else → unmapped.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store funct3: 000 SB, 001 SH, 010 SW. Any other funct3 → fault.
- Load formatting: LB/LBU select byte `addr[1:0]`; LH/LHU select half `addr[1]`; LB/LH sign-extend, LBU/LHU zero-extend.
- Store: byte enables are SB `4'b0001<<addr[1:0]` and SH `4'b0011<<{addr[1],1'b0}`. Data is replicated across lanes.
- GPIO store: any width writes `gpio <= req_wdata[7:0]`. GPIO load: word `{24'b0,gpio}`, then formatted.
- Faults: unmapped address, store to ROM, illegal funct3, misaligned access (see Configuration). A fault gives `resp_fault`=1 and `resp_rdata`=0; RAM and `gpio` are unchanged.
- FSM, one-hot:
  - IDLE → ACCESS on `req_valid && req_ready`. Address, we, funct3, wdata and fault flag are latched; RAM read address is registered.
  - ACCESS → RESP unconditionally. `rom_addr` is driven from latched `addr[11:2]`. RAM/GPIO store commits on the exiting edge. Load data is captured into `resp_rdata`.
  - RESP → IDLE unconditionally; `resp_valid`=1 for this cycle only.
- Store in RESP: `resp_rdata`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `gpio`=0, `rom_addr`=0. RAM contents are not reset.
- Fixed latency: accept at edge N; `resp_valid` is high during cycle N+2; `req_ready` returns at N+3. Throughput is one access per 3 cycles, for every access type including faults.
- `req_*` are sampled only at the accept edge and may change afterwards.
- `req_valid` while not ready: the request is ignored and must be held by the producer.
- Back-to-back store then load to the same RAM word: the load returns the new data, since the store commits before the load's read.
- `rst` asserted mid-operation: immediate return to IDLE with no response. A store whose ACCESS-exit edge has not occurred is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, faults.
- Undefined: misalignment never faults. Low address bits below the access size are forced to 0 (e.g. LW 0x1006 reads word 0x1004), and no `resp_fault` is raised for alignment.

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), region constants (`REGION_ROM/RAM/GPIO`, `GPIO_ADDR`=32'h2000), FSM state encoding.
- Sub-module `data_ram`: synchronous-read, byte-enable write, `RAM_WORDS`×32, no reset.
- Alignment, formatting and fault logic live in the top module.

## Test plan
- Reset: assert `rst` mid-ACCESS of SW 0x1000 ← 0xDEADBEEF. Required: `resp_valid` never asserted, and a later LW 0x1000 returns the prior value.
- SW 0x1000 ← 0x0001F000, then LW 0x1000. Required: `resp_rdata`=0x0001F000, `resp_valid` exactly 2 cycles after each accept, `req_ready` low for 2 cycles.
- SW 0x1004 ← 0x80FF7F01. Then LB 0x1006 → 0xFFFFFFFF; LBU 0x1007 → 0x00000080; LH 0x1006 → 0xFFFF80FF; LHU 0x1004 → 0x00007F01.
- SB 0x1005 ← 0x000000AA over the prior word. Required: LW 0x1004 → 0x80FFAA01.
- SB 0x2000 ← 0x1234_56C3. Required: `gpio`=0xC3 and LW 0x2000 → 0x000000C3. Also: SW 0x0000 → fault with RAM unchanged; LW 0x3000 → fault with rdata 0.
- LW 0x1002:
  - With `LSU_MISALIGN_TRAP_EN`: `resp_fault`=1.
  - Without it: returns the word at 0x1000 with `resp_fault`=0.
